cascade_down_counter: RTL and testbench

Parametrised multi-digit modulo counter, successor to the single-digit 9-to-0 counter used in the timer datapath. It chains `DIGITS` modulo-`MODULUS` digits with internal borrow/carry, counts one step per rising edge of `in_pulse`, and supports parallel load, up/down direction and a wrap-or-saturate mode. It emits a one-cycle `out_pulse` when the count reaches its terminal value. It feeds the seven-segment display decoders and the game-over logic.

---
 rtl/cascade_down_counter.sv | 97 +++++++++
 tb/tb_cascade_down_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cascade_down_counter.sv
// Cascaded modulo-MODULUS counter with edge-detected stepping, parallel load,
// up/down direction and wrap-or-saturate behaviour at the terminal count.

module cascade_digit #(
   parameter int MODULUS = 10,
   parameter int DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] d,
   input  logic               up,
   input  logic               cin,
   output logic [DIGIT_W-1:0] d_nxt,
   output logic               is_zero,
   output logic               is_max
);
   localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MODULUS - 1);

   assign is_zero = (d == '0);
   assign is_max  = (d == MAX_D);

   always_comb begin
      d_nxt = d;
      if (cin) begin
         if (up) d_nxt = is_max  ? '0    : d + 1'b1;
         else    d_nxt = is_zero ? MAX_D : d - 1'b1;
      end
   end
endmodule

module cascade_down_counter #(
   parameter int DIGITS  = 4,
   parameter int MODULUS = 10,
   parameter int DIGIT_W = 4,
   parameter bit WRAP    = 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      enable,
   input  logic                      in_pulse,
   input  logic                      up,
   input  logic                      load,
   input  logic [DIGITS*DIGIT_W-1:0] load_value,
   output logic [DIGITS*DIGIT_W-1:0] cur_value,
   output logic                      out_pulse,
   output logic                      at_terminal
);
   localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MODULUS - 1);
   localparam logic [DIGIT_W:0]   MOD_W = (DIGIT_W+1)'(MODULUS);

   logic [DIGITS-1:0][DIGIT_W-1:0] digit_q, digit_nxt, ld_clamp;
   logic [DIGITS-1:0]              chain, is_zero, is_max, term_nxt;
   logic                           prev, step, step_ok;

   // chain[i]: the step reaches digit i (every lower digit borrows/carries)
   assign chain[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      if (i > 0) begin : g_chain
         assign chain[i] = chain[i-1] & (up ? is_max[i-1] : is_zero[i-1]);
      end

      cascade_digit #(.MODULUS(MODULUS), .DIGIT_W(DIGIT_W)) u_digit (
         .d       (digit_q[i]),
         .up      (up),
         .cin     (chain[i]),
         .d_nxt   (digit_nxt[i]),
         .is_zero (is_zero[i]),
         .is_max  (is_max[i])
      );

      assign ld_clamp[i] = ({1'b0, load_value[i*DIGIT_W +: DIGIT_W]} >= MOD_W) ?
                           MAX_D : load_value[i*DIGIT_W +: DIGIT_W];
      assign term_nxt[i] = up ? (digit_nxt[i] == MAX_D) : (digit_nxt[i] == '0);
   end

   assign at_terminal = up ? (&is_max) : (&is_zero);
   assign step        = in_pulse & ~prev & enable;
   assign step_ok     = step & (WRAP | ~at_terminal);
   assign cur_value   = digit_q;

   // A wrap out of terminal lands on the opposite extreme, so term_nxt stays low
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         digit_q   <= {DIGITS{MAX_D}};
         prev      <= 1'b0;
         out_pulse <= 1'b0;
      end else begin
         prev      <= in_pulse;
         out_pulse <= 1'b0;
         if (load) begin
            digit_q <= ld_clamp;
         end else if (step_ok) begin
            digit_q   <= digit_nxt;
            out_pulse <= &term_nxt;
         end
      end
   end
endmodule

// File: tb/tb_cascade_down_counter.sv
// Directed bench: default 4-digit decade counter plus MOD6, saturating and
// 2-digit wrapping variants sharing one stimulus bus.

module tb_cascade_down_counter;
   logic        clk = 1'b0;
   logic        resetn, enable, in_pulse, up, load;
   logic [15:0] lv16;
   logic [7:0]  lv8;
   logic [15:0] cur0, cur1;
   logic [7:0]  cur2, cur3;
   logic        op0, op1, op2, op3, at0, at1, at2, at3;
   int          total = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   cascade_down_counter u0 (
      .clk(clk), .resetn(resetn), .enable(enable), .in_pulse(in_pulse), .up(up),
      .load(load), .load_value(lv16), .cur_value(cur0), .out_pulse(op0), .at_terminal(at0));
   cascade_down_counter #(.MODULUS(6)) u1 (
      .clk(clk), .resetn(resetn), .enable(enable), .in_pulse(in_pulse), .up(up),
      .load(load), .load_value(lv16), .cur_value(cur1), .out_pulse(op1), .at_terminal(at1));
   cascade_down_counter #(.DIGITS(2), .WRAP(0)) u2 (
      .clk(clk), .resetn(resetn), .enable(enable), .in_pulse(in_pulse), .up(up),
      .load(load), .load_value(lv8), .cur_value(cur2), .out_pulse(op2), .at_terminal(at2));
   cascade_down_counter #(.DIGITS(2)) u3 (
      .clk(clk), .resetn(resetn), .enable(enable), .in_pulse(in_pulse), .up(up),
      .load(load), .load_value(lv8), .cur_value(cur3), .out_pulse(op3), .at_terminal(at3));

   typedef struct {
      logic        ld;
      logic [15:0] lv;
      logic        inp;
      logic        en;
      logic        up;
      logic [15:0] ev;
      logic        ep;
   } vec_t;

   vec_t tbl[33];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ld, input logic inp);
      load     = ld;
      in_pulse = inp;
      tick();
   endtask

   int pulses;
   logic last_pulse;

   initial begin
      resetn = 1'b0; enable = 1'b1; in_pulse = 1'b0; up = 1'b0; load = 1'b0;
      lv16 = '0; lv8 = '0;
      #13;
      chk("reset_cur0", cur0, 16'h9999);
      chk("reset_pulse0", op0, 1'b0);
      chk("reset_cur1", cur1, 16'h5555);
      chk("reset_cur2", cur2, 8'h99);
      #4 resetn = 1'b1;
      tick();

      // full down-count from 9999 to 0000
      pulses = 0; last_pulse = 1'b0;
      for (int i = 1; i <= 9999; i++) begin
         drive(1'b0, 1'b1);
         if (op0) pulses++;
         last_pulse = op0;
         if (i < 9999) drive(1'b0, 1'b0);
      end
      chk("run_cur", cur0, 16'h0000);
      chk("run_pulse_count", pulses, 1);
      chk("run_pulse_last", last_pulse, 1'b1);
      chk("run_at_term", at0, 1'b1);
      drive(1'b0, 1'b0);
      chk("run_pulse_width", op0, 1'b0);
      drive(1'b0, 1'b1);
      chk("wrap_cur", cur0, 16'h9999);
      chk("wrap_pulse", op0, 1'b0);
      drive(1'b0, 1'b0);

      //            ld    lv        inp   en    up    ev        ep
      tbl[0]  = '{1'b1, 16'h1000, 1'b0, 1'b1, 1'b0, 16'h1000, 1'b0};
      tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0999, 1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0999, 1'b0};
      tbl[3]  = '{1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0099, 1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0099, 1'b0};
      for (int i = 6; i < 16; i++)
         tbl[i] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0098, 1'b0};
      tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0098, 1'b0};
      tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0098, 1'b0};
      tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0098, 1'b0};
      tbl[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0098, 1'b0};
      tbl[20] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0098, 1'b0};
      tbl[21] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0098, 1'b0};
      tbl[22] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0097, 1'b0};
      tbl[23] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0097, 1'b0};
      tbl[24] = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0};
      tbl[25] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0};
      tbl[26] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
      tbl[27] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
      tbl[28] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0};
      tbl[29] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0};
      tbl[30] = '{1'b1, 16'h9998, 1'b0, 1'b1, 1'b1, 16'h9998, 1'b0};
      tbl[31] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h9999, 1'b1};
      tbl[32] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h9999, 1'b0};

      for (int i = 0; i < 33; i++) begin
         lv16 = tbl[i].lv; enable = tbl[i].en; up = tbl[i].up;
         drive(tbl[i].ld, tbl[i].inp);
         chk($sformatf("vec%0d_cur", i), cur0, tbl[i].ev);
         chk($sformatf("vec%0d_pulse", i), op0, tbl[i].ep);
      end

      // MOD6: clamp on load, coincident edge discarded
      up = 1'b0; enable = 1'b1;
      lv16 = 16'h7302;
      drive(1'b1, 1'b1);
      chk("mod6_load_cur", cur1, 16'h5302);
      chk("mod6_load_pulse", op1, 1'b0);
      drive(1'b0, 1'b0);
      chk("mod6_hold", cur1, 16'h5302);
      lv16 = 16'h1000;
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      chk("mod6_borrow", cur1, 16'h0555);
      drive(1'b0, 1'b0);

      // WRAP=0 saturation on u2
      lv8 = 8'h01;
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      chk("sat_reach", cur2, 8'h00);
      chk("sat_reach_pulse", op2, 1'b1);
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0);
         drive(1'b0, 1'b1);
         chk($sformatf("sat_hold%0d", k), cur2, 8'h00);
         chk($sformatf("sat_hold_pulse%0d", k), op2, 1'b0);
      end
      chk("sat_at_term", at2, 1'b1);
      drive(1'b0, 1'b0);
      up = 1'b1;
      #1 chk("sat_at_term_up", at2, 1'b0);
      drive(1'b0, 1'b1);
      chk("sat_up", cur2, 8'h01);
      drive(1'b0, 1'b0);

      // up mode and mid-cycle reset on u3
      lv8 = 8'h98;
      drive(1'b1, 1'b0);
      chk("up_load", cur3, 8'h98);
      drive(1'b0, 1'b1);
      chk("up_reach", cur3, 8'h99);
      chk("up_reach_pulse", op3, 1'b1);
      drive(1'b0, 1'b0);
      chk("up_pulse_width", op3, 1'b0);
      drive(1'b0, 1'b1);
      chk("up_wrap", cur3, 8'h00);
      chk("up_wrap_pulse", op3, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      chk("up_reach2_pulse", op3, 1'b1);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_cur", cur3, 8'h99);
      chk("async_rst_pulse", op3, 1'b0);
      chk("async_rst_cur0", cur0, 16'h9999);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
